alu_issue_stage: RTL and testbench

- Operand-fetch/issue stage directly upstream of the 16-bit ALU (add/sub/and/or, 4-bit op select).
- Accepts 16-bit instructions over a valid/ready handshake and reads two source registers from an internal 8-entry register file.
- Drives registered operands and the op code to the ALU, then writes the ALU's combinational result back to the destination register one cycle later.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_stage.sv | 113 +++++++++++
 tb/tb_alu_issue_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: opcodes, instruction field positions and widths.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_NREGS  = 8;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned REG_AW     = 3;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned IMM_W      = 9;

    // Instruction field LSB positions: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS_LSB  = 6;
    localparam int unsigned RT_LSB  = 3;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;

    // Register-register ops: the only ones that read rs/rt and can hazard.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return is_alu_op(op) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: three combinational read ports (rs, rt, debug), one synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding a 16-bit ALU, with writeback one cycle after issue.
// Optional operand bypass from alu_out is enabled with `define ALU_ISSUE_FORWARD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NREGS  = DEF_NREGS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               err_illegal,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [IMM_W-1:0]  imm;

    assign op  = in_instr[OP_LSB  +: OP_W];
    assign rd  = in_instr[RD_LSB  +: REG_AW];
    assign rs  = in_instr[RS_LSB  +: REG_AW];
    assign rt  = in_instr[RT_LSB  +: REG_AW];
    assign imm = in_instr[IMM_LSB +: IMM_W];

    logic              v_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              accept;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs),
        .rt_addr  (rt),
        .dbg_addr (dbg_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_data),
        .wr_en    (v_q),
        .wr_addr  (rd_q),
        .wr_data  (alu_out)
    );

`ifdef ALU_ISSUE_FORWARD_EN
    // The in-flight result is written at the same edge we issue, so bypass it instead of stalling.
    assign opa      = (v_q && (rd_q == rs)) ? alu_out : rs_data;
    assign opb      = (v_q && (rd_q == rt)) ? alu_out : rt_data;
    assign in_ready = 1'b1;
`else
    // RAW on the in-flight destination: wait one cycle for the write to land (v_q drops meanwhile).
    assign opa      = rs_data;
    assign opb      = rt_data;
    assign in_ready = !(v_q && in_valid && is_alu_op(op) && ((rs == rd_q) || (rt == rd_q)));
`endif

    assign accept = in_valid && in_ready;

    // Issue register; illegal ops become a NOP that only pulses err_illegal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= 1'b0;
            rd_q        <= '0;
            alu_op      <= OP_ADD;
            alu_a       <= '0;
            alu_b       <= '0;
            err_illegal <= 1'b0;
        end else begin
            v_q         <= 1'b0;
            err_illegal <= 1'b0;
            if (accept) begin
                if (!is_legal_op(op)) begin
                    err_illegal <= 1'b1;
                end else begin
                    v_q  <= 1'b1;
                    rd_q <= rd;
                    if (op == OP_LDI) begin
                        alu_op <= OP_ADD;
                        alu_a  <= DATA_W'(imm);
                        alu_b  <= '0;
                    end else begin
                        alu_op <= op;
                        alu_a  <= opa;
                        alu_b  <= opb;
                    end
                end
            end
        end
    end

    assign wb_valid = v_q;
    assign wb_rd    = rd_q;
    assign wb_data  = alu_out;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; the bench itself models the downstream ALU.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err_illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;
    int st;
    int total;

`ifdef ALU_ISSUE_FORWARD_EN
    localparam int HAZ_STALL = 0;
`else
    localparam int HAZ_STALL = 1;
`endif

    alu_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Downstream ALU model
    always_comb begin
        case (alu_op)
            4'h1:    alu_out = alu_a - alu_b;
            4'h2:    alu_out = alu_a & alu_b;
            4'h3:    alu_out = alu_a | alu_b;
            default: alu_out = alu_a + alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction from a negedge; return at the negedge after it is accepted.
    task automatic send(input logic [15:0] ins, output int stalls);
        in_valid = 1'b1;
        in_instr = ins;
        stalls   = 0;
        #1;
        while (!in_ready && stalls < 10) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 10) check("send_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic dbg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        @(negedge clk);

        // 1: LDI R1,5; LDI R2,3; ADD R3,R1,R2
        send(16'h8205, st);
        check("t1_ldi_wb_valid", 32'(wb_valid), 32'd1);
        check("t1_ldi_wb_rd", 32'(wb_rd), 32'd1);
        check("t1_ldi_wb_data", 32'(wb_data), 32'd5);
        send(16'h8403, st);
        check("t1_ldi2_stall", 32'(st), 32'd0);
        send(16'h0650, st);
        check("t1_add_stall", 32'(st), 32'(HAZ_STALL));
        check("t1_add_wb_data", 32'(wb_data), 32'd8);
        check("t1_add_wb_rd", 32'(wb_rd), 32'd3);
        @(negedge clk);
        check("t1_idle_wb_valid", 32'(wb_valid), 32'd0);
        dbg(3'd3, 16'd8, "t1_dbg_r3");

        // 2: max imm9 loads then dependent SUB
        @(negedge clk);
        send(16'h83FF, st);
        send(16'h85FF, st);
        send(16'h1888, st);
        check("t2_sub_stall", 32'(st), 32'(HAZ_STALL));
        check("t2_sub_alu_a", 32'(alu_a), 32'h1FF);
        check("t2_sub_alu_op", 32'(alu_op), 32'd1);
        @(negedge clk);
        dbg(3'd4, 16'd0, "t2_dbg_r4");

        // 3: ADD R1,R1,R1 x4 from R1=1
        @(negedge clk);
        send(16'h8201, st);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            send(16'h0248, st);
            total += st;
        end
        check("t3_total_stalls", 32'(total), 32'(4 * HAZ_STALL));
        @(negedge clk);
        dbg(3'd1, 16'd16, "t3_dbg_r1");

        // 4: illegal op 5 targeting R7, then LDI R6,0x2A right behind it
        @(negedge clk);
        send(16'h5E48, st);
        check("t4_err", 32'(err_illegal), 32'd1);
        check("t4_wb_valid", 32'(wb_valid), 32'd0);
        check("t4_alu_a_hold", 32'(alu_a), 32'd8);
        send(16'h8C2A, st);
        check("t4_next_stall", 32'(st), 32'd0);
        check("t4_err_pulse", 32'(err_illegal), 32'd0);
        check("t4_next_wb_valid", 32'(wb_valid), 32'd1);
        @(negedge clk);
        dbg(3'd7, 16'd0, "t4_dbg_r7");
        dbg(3'd6, 16'h002A, "t4_dbg_r6");

        // 5: SUB wrap, AND, OR
        @(negedge clk);
        send(16'h8200, st);
        send(16'h8401, st);
        send(16'h1650, st);
        check("t5_sub_wb_data", 32'(wb_data), 32'hFFFF);
        send(16'h82F0, st);
        send(16'h8BFE, st);
        send(16'h0B68, st);
        send(16'h0B68, st);
        send(16'h0B68, st);
        check("t5_r5_build", 32'(wb_data), 32'h0FF0);
        send(16'h2C68, st);
        check("t5_and_wb_data", 32'(wb_data), 32'h00F0);
        send(16'h3E68, st);
        check("t5_or_stall", 32'(st), 32'd0);
        check("t5_or_wb_data", 32'(wb_data), 32'h0FF0);
        @(negedge clk);
        dbg(3'd7, 16'h0FF0, "t5_dbg_r7");

        // 6: reset in the writeback cycle of ADD R5,R1,R1
        @(negedge clk);
        send(16'h0A48, st);
        check("t6_add_alu_a", 32'(alu_a), 32'h00F0);
        reset = 1'b1;
        #1;
        check("t6_rst_alu_a", 32'(alu_a), 32'd0);
        check("t6_rst_alu_b", 32'(alu_b), 32'd0);
        check("t6_rst_alu_op", 32'(alu_op), 32'd0);
        check("t6_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("t6_rst_wb_rd", 32'(wb_rd), 32'd0);
        check("t6_rst_err", 32'(err_illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        dbg(3'd5, 16'd0, "t6_dbg_r5");
        dbg(3'd1, 16'd0, "t6_dbg_r1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
